// File: rtl/acpo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acpo_pkg
// Description : Shared types and helpers for the activation + pooling back end
//               (act_pool_array / act_pool_lane).
//               - pool_mode_e  : max / average pooling selector
//               - lane_state_e : conv-lane frame state
//               - relu()       : ReLU on a sign-extended sample
// Revision    : 1.0 - initial release
// ============================================================================
package acpo_pkg;

    typedef enum logic [0:0] {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_e;

    // relu() works on a fixed wide signed value so one function serves every
    // DATA_WIDTH up to this size; callers sign-extend in and truncate out.
    localparam int RELU_W = 32;

    function automatic logic signed [RELU_W-1:0] relu(
        input logic signed [RELU_W-1:0] x,
        input logic                     en
    );
        logic signed [RELU_W-1:0] y;
        y = x;
        if (en && (x < 0)) begin
            y = '0;
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_pool_lane.sv
`default_nettype none
// ============================================================================
// Module      : act_pool_lane
// Description : One conv lane: ReLU/bypass (stage 1) followed by 2x2 stride-2
//               max/avg pooling or pass-through (stage 2) over a row-major
//               stream, with a half-row line buffer and output address counter.
//               Latency input -> output is 2 cycles.
// Ports       : clk, rst (sync, active high)
//               cfg_relu_en / cfg_pool_en / cfg_pool_mode / cfg_fmap_w
//                   - latched on the first valid sample of a frame
//               valid_i, last_i, result_i      - accumulator sample stream
//               pool_valid_o, pool_last_o, pool_result_o,
//               pool_result_address_o          - pooled result + write address
// Revision    : 1.0 - initial release
// ============================================================================
module act_pool_lane
    import acpo_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int ADDRESS_WIDTH = 10,
    parameter  int MAX_FMAP_W    = 32,
    localparam int W_W           = $clog2(MAX_FMAP_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_relu_en,
    input  logic                     cfg_pool_en,
    input  logic                     cfg_pool_mode,
    input  logic [W_W-1:0]           cfg_fmap_w,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic [DATA_WIDTH-1:0]    result_i,
    output logic                     pool_valid_o,
    output logic                     pool_last_o,
    output logic [DATA_WIDTH-1:0]    pool_result_o,
    output logic [ADDRESS_WIDTH-1:0] pool_result_address_o
);

    localparam int LB_DEPTH = (MAX_FMAP_W / 2 > 0) ? MAX_FMAP_W / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int PW       = DATA_WIDTH + 1;   // horizontal pair (sum needs 1 extra bit)
    localparam int SW       = DATA_WIDTH + 2;   // 4-sample window sum
    localparam logic [W_W-1:0] W_MAX = W_W'(MAX_FMAP_W);

    // ---------------- frame state / latched configuration ----------------
    lane_state_e        state_q, state_d;
    logic               cfg_relu_q, cfg_relu_d;
    logic               cfg_pool_q, cfg_pool_d;
    pool_mode_e         cfg_mode_q, cfg_mode_d;
    logic [W_W-1:0]     cfg_w_q, cfg_w_d;

    logic               eff_relu;
    logic               eff_pool;
    pool_mode_e         eff_mode;
    logic [W_W-1:0]     eff_w;
    logic [W_W-1:0]     live_w;
    logic signed [RELU_W-1:0] relu_out;

    // ---------------- stage 1 ----------------
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_pool_q, s1_pool_d;
    pool_mode_e            s1_mode_q, s1_mode_d;
    logic [W_W-1:0]        s1_w_q, s1_w_d;

    // ---------------- stage 2 ----------------
    logic [W_W-1:0]           col_q, col_d;
    logic                     row_odd_q, row_odd_d;
    logic [DATA_WIDTH-1:0]    prev_q, prev_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic [ADDRESS_WIDTH-1:0] out_addr_q, out_addr_d;

    logic [PW-1:0]            lb_q [LB_DEPTH];
    logic                     lb_we;
    logic [LB_AW-1:0]         lb_idx;

    logic signed [DATA_WIDTH-1:0] prev_s, cur_s, pair_max, lb_max, win_max;
    logic signed [PW-1:0]         pair_sum, pair_val, lb_rd;
    logic signed [SW-1:0]         win_sum, win_avg;
    logic [DATA_WIDTH-1:0]        win_res;

    // Stage 1 + frame FSM. In IDLE the live configuration applies to the
    // sample arriving now; from RUN onwards the latched copy is used.
    always_comb begin
        state_d    = state_q;
        cfg_relu_d = cfg_relu_q;
        cfg_pool_d = cfg_pool_q;
        cfg_mode_d = cfg_mode_q;
        cfg_w_d    = cfg_w_q;

        live_w   = (cfg_fmap_w > W_MAX) ? W_MAX : cfg_fmap_w;
        eff_relu = (state_q == IDLE) ? cfg_relu_en : cfg_relu_q;
        eff_pool = (state_q == IDLE) ? cfg_pool_en : cfg_pool_q;
        eff_mode = (state_q == IDLE) ? pool_mode_e'(cfg_pool_mode) : cfg_mode_q;
        eff_w    = (state_q == IDLE) ? live_w : cfg_w_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    cfg_relu_d = cfg_relu_en;
                    cfg_pool_d = cfg_pool_en;
                    cfg_mode_d = pool_mode_e'(cfg_pool_mode);
                    cfg_w_d    = live_w;
                    // A one-sample frame opens and closes in the same cycle.
                    if (!last_i) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (valid_i && last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        relu_out   = relu(RELU_W'($signed(result_i)), eff_relu);
        s1_valid_d = valid_i;
        s1_last_d  = valid_i & last_i;
        s1_data_d  = DATA_WIDTH'(relu_out);
        s1_pool_d  = eff_pool;
        s1_mode_d  = eff_mode;
        s1_w_d     = eff_w;
    end

    // Window arithmetic. The line buffer holds the even-row pair, either as a
    // sign-extended max or as a full-precision sum, depending on the mode.
    always_comb begin
        lb_idx   = LB_AW'(col_q >> 1);
        prev_s   = $signed(prev_q);
        cur_s    = $signed(s1_data_q);
        pair_max = (cur_s > prev_s) ? cur_s : prev_s;
        pair_sum = PW'(prev_s) + PW'(cur_s);
        pair_val = (s1_mode_q == POOL_AVG) ? pair_sum : PW'(pair_max);
        lb_rd    = $signed(lb_q[lb_idx]);
        lb_max   = DATA_WIDTH'(lb_rd);
        win_max  = (lb_max > pair_max) ? lb_max : pair_max;
        win_sum  = SW'(lb_rd) + SW'(pair_sum);
        win_avg  = win_sum >>> 2;   // arithmetic shift: floor division
        win_res  = (s1_mode_q == POOL_AVG) ? DATA_WIDTH'(win_avg) : win_max;
    end

    // Stage 2: column/row tracking, pooling decision, address generation.
    always_comb begin
        col_d       = col_q;
        row_odd_d   = row_odd_q;
        prev_d      = prev_q;
        addr_d      = addr_q;
        lb_we       = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
        out_addr_d  = '0;

        if (s1_valid_q) begin
            if (!s1_pool_q) begin
                out_valid_d = 1'b1;
                out_data_d  = s1_data_q;
                out_addr_d  = addr_q;
                addr_d      = addr_q + ADDRESS_WIDTH'(1);
            end else if (s1_w_q >= W_W'(2)) begin
                if (col_q[0]) begin
                    if (!row_odd_q) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = win_res;
                        out_addr_d  = addr_q;
                        addr_d      = addr_q + ADDRESS_WIDTH'(1);
                    end
                end else begin
                    prev_d = s1_data_q;
                end
                // With odd width the trailing even column lands in prev and
                // is simply overwritten by the next row's first sample.
                if (col_q == s1_w_q - W_W'(1)) begin
                    col_d     = '0;
                    row_odd_d = ~row_odd_q;
                end else begin
                    col_d = col_q + W_W'(1);
                end
            end

            if (s1_last_q) begin
                out_last_d = 1'b1;
                col_d      = '0;
                row_odd_d  = 1'b0;
                addr_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_relu_q  <= 1'b0;
            cfg_pool_q  <= 1'b0;
            cfg_mode_q  <= POOL_MAX;
            cfg_w_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            s1_pool_q   <= 1'b0;
            s1_mode_q   <= POOL_MAX;
            s1_w_q      <= '0;
            col_q       <= '0;
            row_odd_q   <= 1'b0;
            prev_q      <= '0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_relu_q  <= cfg_relu_d;
            cfg_pool_q  <= cfg_pool_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_w_q     <= cfg_w_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            s1_pool_q   <= s1_pool_d;
            s1_mode_q   <= s1_mode_d;
            s1_w_q      <= s1_w_d;
            col_q       <= col_d;
            row_odd_q   <= row_odd_d;
            prev_q      <= prev_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    // Line buffer is only read for windows whose even row was written this
    // frame, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= pair_val;
        end
    end

    assign pool_valid_o          = out_valid_q;
    assign pool_last_o           = out_last_q;
    assign pool_result_o         = out_data_q;
    assign pool_result_address_o = out_addr_q;

endmodule
`default_nettype wire

// File: rtl/act_pool_array.sv
`default_nettype none
// ============================================================================
// Module      : act_pool_array
// Description : Activation + pooling back end of the systolic array.
//               POOL_NUM conv lanes (ReLU + 2x2 pooling + address generation)
//               and FA_NUM fully-connected lanes (ReLU only). Every lane has
//               a 2-cycle latency and no backpressure.
// Ports       : clk, rst (sync, active high)
//               cfg_relu_en, cfg_pool_en, cfg_pool_mode, cfg_fmap_w
//               acc_valid_i / acc_last_i / acc_result_i   [POOL_NUM]
//               fa_valid_i  / fa_last_i  / fa_result_i    [FA_NUM]
//               pool_valid_o / pool_last_o / pool_result_o /
//               pool_result_address_o                     [POOL_NUM]
//               act_valid_o / act_last_o / act_result_o   [FA_NUM]
// Revision    : 1.0 - initial release
// ============================================================================
module act_pool_array
    import acpo_pkg::*;
#(
    parameter  int POOL_NUM      = 16,
    parameter  int FA_NUM        = 1,
    parameter  int DATA_WIDTH    = 8,
    parameter  int ADDRESS_WIDTH = 10,
    parameter  int MAX_FMAP_W    = 32,
    localparam int W_W           = $clog2(MAX_FMAP_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_relu_en,
    input  logic                     cfg_pool_en,
    input  logic                     cfg_pool_mode,
    input  logic [W_W-1:0]           cfg_fmap_w,
    input  logic [POOL_NUM-1:0]      acc_valid_i,
    input  logic [POOL_NUM-1:0]      acc_last_i,
    input  logic [DATA_WIDTH-1:0]    acc_result_i [POOL_NUM],
    input  logic [FA_NUM-1:0]        fa_valid_i,
    input  logic [FA_NUM-1:0]        fa_last_i,
    input  logic [DATA_WIDTH-1:0]    fa_result_i [FA_NUM],
    output logic [POOL_NUM-1:0]      pool_valid_o,
    output logic [POOL_NUM-1:0]      pool_last_o,
    output logic [DATA_WIDTH-1:0]    pool_result_o [POOL_NUM],
    output logic [ADDRESS_WIDTH-1:0] pool_result_address_o [POOL_NUM],
    output logic [FA_NUM-1:0]        act_valid_o,
    output logic [FA_NUM-1:0]        act_last_o,
    output logic [DATA_WIDTH-1:0]    act_result_o [FA_NUM]
);

    for (genvar g = 0; g < POOL_NUM; g++) begin : g_pool
        act_pool_lane #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .MAX_FMAP_W    (MAX_FMAP_W)
        ) u_lane (
            .clk                   (clk),
            .rst                   (rst),
            .cfg_relu_en           (cfg_relu_en),
            .cfg_pool_en           (cfg_pool_en),
            .cfg_pool_mode         (cfg_pool_mode),
            .cfg_fmap_w            (cfg_fmap_w),
            .valid_i               (acc_valid_i[g]),
            .last_i                (acc_last_i[g]),
            .result_i              (acc_result_i[g]),
            .pool_valid_o          (pool_valid_o[g]),
            .pool_last_o           (pool_last_o[g]),
            .pool_result_o         (pool_result_o[g]),
            .pool_result_address_o (pool_result_address_o[g])
        );
    end

    // FA lanes: ReLU stage plus one delay register so they line up with the
    // conv lanes' 2-cycle latency.
    for (genvar f = 0; f < FA_NUM; f++) begin : g_fa
        logic                     s1_valid_q, s1_valid_d;
        logic                     s1_last_q, s1_last_d;
        logic [DATA_WIDTH-1:0]    s1_data_q, s1_data_d;
        logic                     out_valid_q, out_valid_d;
        logic                     out_last_q, out_last_d;
        logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
        logic signed [RELU_W-1:0] relu_out;

        always_comb begin
            relu_out    = relu(RELU_W'($signed(fa_result_i[f])), cfg_relu_en);
            s1_valid_d  = fa_valid_i[f];
            s1_last_d   = fa_valid_i[f] & fa_last_i[f];
            s1_data_d   = fa_valid_i[f] ? DATA_WIDTH'(relu_out) : '0;
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            out_data_d  = s1_data_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q  <= 1'b0;
                s1_last_q   <= 1'b0;
                s1_data_q   <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                out_data_q  <= '0;
            end else begin
                s1_valid_q  <= s1_valid_d;
                s1_last_q   <= s1_last_d;
                s1_data_q   <= s1_data_d;
                out_valid_q <= out_valid_d;
                out_last_q  <= out_last_d;
                out_data_q  <= out_data_d;
            end
        end

        assign act_valid_o[f]  = out_valid_q;
        assign act_last_o[f]   = out_last_q;
        assign act_result_o[f] = out_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_act_pool_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_pool_array
// Description : Self-checking bench for act_pool_array. A table of per-cycle
//               records holds the lane inputs and the outputs each record is
//               expected to produce two cycles later; hand-written sequences
//               cover reset mid-frame and the FA lane.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_pool_array;

    localparam int POOL_NUM = 16;
    localparam int FA_NUM   = 1;
    localparam int DW       = 8;
    localparam int AW       = 10;
    localparam int MAXW     = 32;
    localparam int WW       = $clog2(MAXW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_relu_en, cfg_pool_en, cfg_pool_mode;
    logic [WW-1:0] cfg_fmap_w;
    logic [POOL_NUM-1:0] acc_valid_i, acc_last_i;
    logic [DW-1:0] acc_result_i [POOL_NUM];
    logic [FA_NUM-1:0]   fa_valid_i, fa_last_i;
    logic [DW-1:0] fa_result_i [FA_NUM];
    logic [POOL_NUM-1:0] pool_valid_o, pool_last_o;
    logic [DW-1:0] pool_result_o [POOL_NUM];
    logic [AW-1:0] pool_result_address_o [POOL_NUM];
    logic [FA_NUM-1:0]   act_valid_o, act_last_o;
    logic [DW-1:0] act_result_o [FA_NUM];

    always #5 clk = ~clk;

    act_pool_array #(
        .POOL_NUM      (POOL_NUM),
        .FA_NUM        (FA_NUM),
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MAX_FMAP_W    (MAXW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_relu_en           (cfg_relu_en),
        .cfg_pool_en           (cfg_pool_en),
        .cfg_pool_mode         (cfg_pool_mode),
        .cfg_fmap_w            (cfg_fmap_w),
        .acc_valid_i           (acc_valid_i),
        .acc_last_i            (acc_last_i),
        .acc_result_i          (acc_result_i),
        .fa_valid_i            (fa_valid_i),
        .fa_last_i             (fa_last_i),
        .fa_result_i           (fa_result_i),
        .pool_valid_o          (pool_valid_o),
        .pool_last_o           (pool_last_o),
        .pool_result_o         (pool_result_o),
        .pool_result_address_o (pool_result_address_o),
        .act_valid_o           (act_valid_o),
        .act_last_o            (act_last_o),
        .act_result_o          (act_result_o)
    );

    typedef struct {
        logic          relu, pool, mode;
        logic [WW-1:0] w;
        logic          v, l;
        logic [DW-1:0] x;
        logic          ev, el;
        logic [DW-1:0] ey;
        logic [AW-1:0] ea;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic relu, input logic pool, input logic mode,
                                input logic [WW-1:0] w, input logic v, input logic l,
                                input logic [DW-1:0] x);
        vec_t r;
        r.relu = relu; r.pool = pool; r.mode = mode; r.w = w;
        r.v = v; r.l = l; r.x = x;
        r.ev = 1'b0; r.el = 1'b0; r.ey = '0; r.ea = '0;
        return r;
    endfunction

    task automatic push(input logic relu, input logic pool, input logic mode,
                        input logic [WW-1:0] w, input logic v, input logic l,
                        input logic [DW-1:0] x, input logic ev, input logic el,
                        input logic [DW-1:0] ey, input logic [AW-1:0] ea);
        vec_t r;
        r = mk(relu, pool, mode, w, v, l, x);
        r.ev = ev; r.el = el; r.ey = ey; r.ea = ea;
        vecs.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        cfg_relu_en   = r.relu;
        cfg_pool_en   = r.pool;
        cfg_pool_mode = r.mode;
        cfg_fmap_w    = r.w;
        for (int j = 0; j < POOL_NUM; j++) begin
            acc_valid_i[j]  = r.v;
            acc_last_i[j]   = r.l;
            acc_result_i[j] = r.x;
        end
    endtask

    task automatic check_out(input vec_t r, input int idx);
        int ln;
        for (int s = 0; s < 2; s++) begin
            ln = (s == 0) ? 0 : POOL_NUM - 1;
            chk($sformatf("vec%0d lane%0d valid", idx, ln), 32'(pool_valid_o[ln]), 32'(r.ev));
            chk($sformatf("vec%0d lane%0d last", idx, ln), 32'(pool_last_o[ln]), 32'(r.el));
            if (r.ev) begin
                chk($sformatf("vec%0d lane%0d data", idx, ln), 32'(pool_result_o[ln]), 32'(r.ey));
                chk($sformatf("vec%0d lane%0d addr", idx, ln), 32'(pool_result_address_o[ln]), 32'(r.ea));
            end
        end
    endtask

    // Record i is sampled at edge i; its result is visible after edge i+1.
    task automatic run_table();
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) drive(vecs[i]);
            else drive(mk(0, 0, 0, '0, 0, 0, '0));
            @(posedge clk); #1;
            if (i > 0) check_out(vecs[i-1], i - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(mk(0, 0, 0, '0, 0, 0, '0));
        fa_valid_i = '0; fa_last_i = '0; fa_result_i[0] = '0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        chk("reset pool_valid", 32'(pool_valid_o), 32'h0);
        chk("reset pool_last", 32'(pool_last_o), 32'h0);
        chk("reset lane0 data", 32'(pool_result_o[0]), 32'h0);
        chk("reset lane0 addr", 32'(pool_result_address_o[0]), 32'h0);
        chk("reset act_valid", 32'(act_valid_o), 32'h0);
        chk("reset act_data", 32'(act_result_o[0]), 32'h0);
        rst = 1'b0;

        // A: relu on, pool off: -5,3,127,-128 -> 0,3,127,0 at addr 0..3
        push(1, 0, 0, 6'd4, 1, 0, 8'hFB, 1, 0, 8'h00, 10'd0);
        push(1, 0, 0, 6'd4, 1, 0, 8'h03, 1, 0, 8'h03, 10'd1);
        push(1, 0, 0, 6'd4, 1, 0, 8'h7F, 1, 0, 8'h7F, 10'd2);
        push(1, 0, 0, 6'd4, 1, 1, 8'h80, 1, 1, 8'h00, 10'd3);
        push(0, 0, 0, 6'd0, 0, 0, 8'h00, 0, 0, 8'h00, 10'd0);

        // B: max, W=4, 4x4 frame 0..15 -> 5,7,13,15 at addr 0..3, last with 15
        for (int k = 0; k < 16; k++) begin
            push(0, 1, 0, 6'd4, 1, k == 15, 8'(k),
                 (k == 5) || (k == 7) || (k == 13) || (k == 15), k == 15, 8'(k),
                 10'((k == 5) ? 0 : (k == 7) ? 1 : (k == 13) ? 2 : 3));
        end

        // C: avg, relu off, W=2: -1,-2,-3,-4 -> floor(-10/4) = -3
        push(0, 1, 1, 6'd2, 1, 0, 8'hFF, 0, 0, 8'h00, 10'd0);
        push(0, 1, 1, 6'd2, 1, 0, 8'hFE, 0, 0, 8'h00, 10'd0);
        push(0, 1, 1, 6'd2, 1, 0, 8'hFD, 0, 0, 8'h00, 10'd0);
        push(0, 1, 1, 6'd2, 1, 1, 8'hFC, 1, 1, 8'hFD, 10'd0);

        // D: W=5, 3 rows of 1s, max -> two outputs, then lone last
        for (int k = 0; k < 15; k++) begin
            push(0, 1, 0, 6'd5, 1, k == 14, 8'd1,
                 (k == 6) || (k == 8), k == 14, 8'd1, 10'((k == 6) ? 0 : 1));
        end

        // E: same as B with gaps; cfg scrambled after the first sample
        push(0, 1, 0, 6'd4, 1, 0, 8'd0, 0, 0, 8'h00, 10'd0);
        for (int k = 1; k < 16; k++) begin
            push(1, 0, 1, 6'd2, 0, 0, 8'hAA, 0, 0, 8'h00, 10'd0);
            push(1, 0, 1, 6'd2, 1, k == 15, 8'(k),
                 (k == 5) || (k == 7) || (k == 13) || (k == 15), k == 15, 8'(k),
                 10'((k == 5) ? 0 : (k == 7) ? 1 : (k == 13) ? 2 : 3));
        end

        // F: pool on with W=1 -> no outputs, last still propagated
        push(0, 1, 0, 6'd1, 1, 0, 8'd9, 0, 0, 8'h00, 10'd0);
        push(0, 1, 0, 6'd1, 1, 1, 8'd9, 0, 1, 8'h00, 10'd0);

        run_table();

        // ---------------- reset mid-frame ----------------
        for (int k = 0; k < 6; k++) begin
            drive(mk(0, 1, 0, 6'd4, 1, 0, 8'(k)));
            @(posedge clk); #1;
        end
        chk("rstmid pre valid", 32'(pool_valid_o[0]), 32'h0);
        rst = 1'b1;
        drive(mk(0, 0, 0, '0, 0, 0, '0));
        @(posedge clk); #1;
        chk("rstmid valid", 32'(pool_valid_o[0]), 32'h0);
        chk("rstmid last", 32'(pool_last_o[0]), 32'h0);
        chk("rstmid data", 32'(pool_result_o[0]), 32'h0);
        chk("rstmid addr", 32'(pool_result_address_o[0]), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid quiet%0d valid", k), 32'(pool_valid_o), 32'h0);
            chk($sformatf("rstmid quiet%0d last", k), 32'(pool_last_o), 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(mk(0, 1, 0, 6'd2, 1, k == 3, 8'(4 - k)));
            @(posedge clk); #1;
        end
        drive(mk(0, 0, 0, '0, 0, 0, '0));
        @(posedge clk); #1;
        chk("rstmid next valid", 32'(pool_valid_o[0]), 32'h1);
        chk("rstmid next data", 32'(pool_result_o[0]), 32'h4);
        chk("rstmid next addr", 32'(pool_result_address_o[0]), 32'h0);
        chk("rstmid next last", 32'(pool_last_o[0]), 32'h1);

        // ---------------- FA lane ----------------
        cfg_relu_en = 1'b1;
        fa_valid_i = 1'b1; fa_last_i = 1'b1; fa_result_i[0] = 8'hF9;  // -7
        @(posedge clk); #1;
        fa_valid_i = 1'b1; fa_last_i = 1'b0; fa_result_i[0] = 8'd42;
        chk("fa lat1 valid", 32'(act_valid_o[0]), 32'h0);
        @(posedge clk); #1;
        fa_valid_i = 1'b0; fa_last_i = 1'b0; fa_result_i[0] = 8'h00;
        chk("fa neg valid", 32'(act_valid_o[0]), 32'h1);
        chk("fa neg last", 32'(act_last_o[0]), 32'h1);
        chk("fa neg data", 32'(act_result_o[0]), 32'h0);
        @(posedge clk); #1;
        chk("fa pos valid", 32'(act_valid_o[0]), 32'h1);
        chk("fa pos last", 32'(act_last_o[0]), 32'h0);
        chk("fa pos data", 32'(act_result_o[0]), 32'd42);
        cfg_relu_en = 1'b0;
        fa_valid_i = 1'b1; fa_last_i = 1'b0; fa_result_i[0] = 8'hF9;
        @(posedge clk); #1;
        fa_valid_i = 1'b0; fa_result_i[0] = 8'h00;
        chk("fa idle valid", 32'(act_valid_o[0]), 32'h0);
        @(posedge clk); #1;
        chk("fa bypass valid", 32'(act_valid_o[0]), 32'h1);
        chk("fa bypass data", 32'(act_result_o[0]), 32'hF9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
